// File: rtl/ats21_pkg.sv
// Shared ATS21 types, instruction field positions and instruction builders.
package ats21_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned HALF_W   = 16;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 29;
    localparam int unsigned ID_MSB   = 28;
    localparam int unsigned ID_LSB   = 26;
    localparam int unsigned RATE_MSB = 25;
    localparam int unsigned RATE_LSB = 16;
    localparam int unsigned TIME_MSB = 15;
    localparam int unsigned TIME_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        SET_CLK   = 3'b001,
        EN_CLK    = 3'b010,
        SET_MODE  = 3'b011,
        SET_ALARM = 3'b101,
        SET_TIMER = 3'b110,
        EN_ALARM  = 3'b111
    } opcode_e;

    typedef enum logic {
        NACK = 1'b0,
        ACK  = 1'b1
    } ack_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDY,
        S_SEND_HI,
        S_SEND_LO,
        S_WAIT_STAT,
        S_RESP
    } state_e;

    typedef struct packed {
        opcode_e                   op;
        logic [OP_LSB-1:0]         fields;
    } ats21_inst_t;

    function automatic logic [INST_W-1:0] mk_inst(input opcode_e op, input logic [OP_LSB-1:0] fields);
        return {op, fields};
    endfunction

    function automatic logic [INST_W-1:0] mk_set_clock(input logic [ID_MSB-ID_LSB:0] id,
                                                       input logic [RATE_MSB-RATE_LSB:0] rate,
                                                       input logic [TIME_MSB-TIME_LSB:0] tm);
        logic [INST_W-1:0] inst;
        inst                     = '0;
        inst[OP_MSB:OP_LSB]      = SET_CLK;
        inst[ID_MSB:ID_LSB]      = id;
        inst[RATE_MSB:RATE_LSB]  = rate;
        inst[TIME_MSB:TIME_LSB]  = tm;
        return inst;
    endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Power-of-two command FIFO with wrap-bit pointers; head is visible while not empty.
module ats21_cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ats21_host_port.sv
// ATS21 client initiator: queues host instructions, runs req/ready, sends two halves, returns Ack/Nack/timeout.
module ats21_host_port
    import ats21_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 2,
    parameter int unsigned RDY_TIMEOUT = 16,
    parameter int unsigned STAT_LAT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [INST_W-1:0] cmd_inst,
    output logic              cmd_ready,
    output logic              resp_valid,
    output logic              resp_ack,
    output logic              resp_timeout,
    output logic [OP_W-1:0]   resp_opcode,
    output logic              busy,
    output logic              req,
    input  logic              ready,
    output logic [HALF_W-1:0] ctrl,
    input  logic              stat
);

    localparam int unsigned CNT_MAX = (RDY_TIMEOUT > STAT_LAT) ? RDY_TIMEOUT : STAT_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    ats21_inst_t       inst, inst_n;
    logic [INST_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              req_n, resp_valid_n;
    logic [HALF_W-1:0] ctrl_n;
    logic              resp_load, timeout_n;
    ack_e              ack_n;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign busy      = !fifo_empty || (state != S_IDLE);

    ats21_cmd_fifo #(
        .WIDTH (INST_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_inst),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next state plus next values of the registered interface outputs.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        inst_n       = inst;
        fifo_pop     = 1'b0;
        resp_load    = 1'b0;
        ack_n        = NACK;
        timeout_n    = 1'b0;
        req_n        = 1'b0;
        resp_valid_n = 1'b0;
        ctrl_n       = '0;

        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    inst_n   = ats21_inst_t'(fifo_head);
                    state_n  = S_REQ;
                end
            end
            S_REQ: begin
                cnt_n   = '0;
                state_n = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                // ready on the final count still wins over the timeout
                if (ready) begin
                    state_n = S_SEND_HI;
                end else if (cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
                    resp_load = 1'b1;
                    timeout_n = 1'b1;
                    state_n   = S_RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_SEND_HI: begin
                state_n = S_SEND_LO;
            end
            S_SEND_LO: begin
                cnt_n   = '0;
                state_n = S_WAIT_STAT;
            end
            S_WAIT_STAT: begin
                if (cnt == CNT_W'(STAT_LAT - 1)) begin
                    resp_load = 1'b1;
                    ack_n     = ack_e'(stat);
                    state_n   = S_RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        req_n        = (state_n == S_REQ);
        resp_valid_n = (state_n == S_RESP);
        if (state_n == S_SEND_HI) begin
            ctrl_n = inst[INST_W-1 -: HALF_W];
        end else if (state_n == S_SEND_LO) begin
            ctrl_n = inst[HALF_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            inst         <= ats21_inst_t'('0);
            req          <= 1'b0;
            ctrl         <= '0;
            resp_valid   <= 1'b0;
            resp_ack     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_opcode  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            inst         <= inst_n;
            req          <= req_n;
            ctrl         <= ctrl_n;
            resp_valid   <= resp_valid_n;
            if (resp_load) begin
                resp_ack     <= (ack_n == ACK);
                resp_timeout <= timeout_n;
                resp_opcode  <= inst.op;
            end
        end
    end

endmodule

// File: tb/tb_ats21_host_port.sv
// Scoreboarded bench for ats21_host_port with a reactive ATS21 responder model.
module tb_ats21_host_port;

    localparam int unsigned CMD_DEPTH   = 2;
    localparam int unsigned RDY_TIMEOUT = 16;
    localparam int unsigned STAT_LAT    = 3;

    typedef struct {
        logic [31:0] inst;
        logic        ack;
        logic        timeout;
        int          rdy_dly;
        logic        late_rdy;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [31:0] cmd_inst;
    logic        cmd_ready;
    logic        resp_valid;
    logic        resp_ack;
    logic        resp_timeout;
    logic [2:0]  resp_opcode;
    logic        busy;
    logic        req;
    logic        ready;
    logic [15:0] ctrl;
    logic        stat;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   resp_en = 1'b1;
    exp_t inst_q[$];
    exp_t resp_q[$];
    int   req_cyc_q[$];

    ats21_host_port #(
        .CMD_DEPTH   (CMD_DEPTH),
        .RDY_TIMEOUT (RDY_TIMEOUT),
        .STAT_LAT    (STAT_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_inst     (cmd_inst),
        .cmd_ready    (cmd_ready),
        .resp_valid   (resp_valid),
        .resp_ack     (resp_ack),
        .resp_timeout (resp_timeout),
        .resp_opcode  (resp_opcode),
        .busy         (busy),
        .req          (req),
        .ready        (ready),
        .ctrl         (ctrl),
        .stat         (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ATS21 client model: answers each req with ready after rdy_dly cycles and checks the halves.
    exp_t re;
    always begin
        @(negedge clk);
        if (resp_en && req === 1'b1) begin
            tests++;
            if (inst_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_req: req=1 with no command queued");
            end else begin
                re = inst_q.pop_front();
                req_cyc_q.push_back(cyc);
                if (re.timeout) begin
                    stat = 1'b1;
                    for (int i = 1; i <= int'(RDY_TIMEOUT) + 1; i++) begin
                        @(negedge clk);
                        if (i == int'(RDY_TIMEOUT) + 1) ready = re.late_rdy;
                        tests++;
                        if (ctrl !== 16'h0) begin
                            fails++;
                            $display("FAIL ctrl_idle_timeout: got %h expected 0000", ctrl);
                        end
                    end
                    @(negedge clk);
                    ready = 1'b0;
                end else begin
                    stat = re.ack;
                    for (int i = 1; i <= re.rdy_dly; i++) begin
                        @(negedge clk);
                        tests++;
                        if (ctrl !== 16'h0) begin
                            fails++;
                            $display("FAIL ctrl_idle_wait: got %h expected 0000", ctrl);
                        end
                    end
                    ready = 1'b1;
                    @(negedge clk);
                    ready = 1'b0;
                    tests++;
                    if (ctrl !== re.inst[31:16]) begin
                        fails++;
                        $display("FAIL ctrl_hi: got %h expected %h", ctrl, re.inst[31:16]);
                    end
                    @(negedge clk);
                    tests++;
                    if (ctrl !== re.inst[15:0]) begin
                        fails++;
                        $display("FAIL ctrl_lo: got %h expected %h", ctrl, re.inst[15:0]);
                    end
                    @(negedge clk);
                    tests++;
                    if (ctrl !== 16'h0) begin
                        fails++;
                        $display("FAIL ctrl_after_lo: got %h expected 0000", ctrl);
                    end
                end
            end
        end
    end

    // Response scoreboard: every resp_valid pulse must match the oldest outstanding command.
    exp_t me;
    int   m_req_cyc;
    int   m_lat;
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            tests++;
            if (resp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: resp_valid=1 opcode=%b with nothing outstanding", resp_opcode);
            end else begin
                me = resp_q.pop_front();
                if (resp_opcode !== me.inst[31:29] || resp_ack !== (me.ack && !me.timeout) ||
                    resp_timeout !== me.timeout) begin
                    fails++;
                    $display("FAIL resp_fields: got op=%b ack=%b to=%b expected op=%b ack=%b to=%b",
                             resp_opcode, resp_ack, resp_timeout, me.inst[31:29],
                             me.ack && !me.timeout, me.timeout);
                end
                m_lat = me.timeout ? int'(RDY_TIMEOUT) + 1 : me.rdy_dly + 3 + int'(STAT_LAT);
                m_req_cyc = (req_cyc_q.size() != 0) ? req_cyc_q.pop_front() : -1000;
                tests++;
                if (cyc - m_req_cyc !== m_lat) begin
                    fails++;
                    $display("FAIL resp_latency: got %0d cycles after req expected %0d", cyc - m_req_cyc, m_lat);
                end
            end
        end
    end

    function automatic exp_t mk_exp(input logic [31:0] inst, input logic ack, input logic to,
                                    input int dly, input logic late);
        exp_t e;
        e.inst = inst; e.ack = ack; e.timeout = to; e.rdy_dly = dly; e.late_rdy = late;
        return e;
    endfunction

    // Offer one command at a negedge; returns one negedge after it was accepted.
    task automatic push_cmd(input exp_t e, input bit track);
        int n = 0;
        cmd_valid = 1'b0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL push_stall: cmd_ready=%b expected 1 within budget", cmd_ready);
        end else begin
            cmd_valid = 1'b1;
            cmd_inst  = e.inst;
            if (track) begin
                inst_q.push_back(e);
                resp_q.push_back(e);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((resp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain: pending=%0d busy=%b expected 0 and 0", resp_q.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_inst = '0; ready = 1'b0; stat = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (req !== 1'b0 || ctrl !== 16'h0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_if: got req=%b ctrl=%h resp_valid=%b expected 0 0000 0", req, ctrl, resp_valid);
        end
        tests++;
        if (resp_ack !== 1'b0 || resp_timeout !== 1'b0 || resp_opcode !== 3'b000) begin
            fails++;
            $display("FAIL reset_resp: got ack=%b to=%b op=%b expected 0 0 000", resp_ack, resp_timeout, resp_opcode);
        end
        tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags: got busy=%b cmd_ready=%b expected 0 1", busy, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        push_cmd(mk_exp(32'h2A40_1234, 1'b1, 1'b0, 1, 1'b0), 1'b1);
        wait_idle(200);
        tests++;
        if (resp_ack !== 1'b1 || resp_opcode !== 3'b001) begin
            fails++;
            $display("FAIL resp_hold: got ack=%b op=%b expected 1 001", resp_ack, resp_opcode);
        end
    endtask

    task automatic test_timeout();
        push_cmd(mk_exp(32'h4000_0001, 1'b0, 1'b1, 0, 1'b0), 1'b1);
        wait_idle(200);
        tests++;
        if (resp_timeout !== 1'b1 || resp_ack !== 1'b0) begin
            fails++;
            $display("FAIL timeout_hold: got to=%b ack=%b expected 1 0", resp_timeout, resp_ack);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        push_cmd(mk_exp(32'h2A40_1234, 1'b1, 1'b0, 1, 1'b0), 1'b1);
        push_cmd(mk_exp(32'hA180_0064, 1'b1, 1'b0, 2, 1'b0), 1'b1);
        push_cmd(mk_exp(32'hE000_0003, 1'b0, 1'b0, 3, 1'b0), 1'b1);
        tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL backpressure: got cmd_ready=%b busy=%b expected 0 1", cmd_ready, busy);
        end
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL ready_rise: cmd_ready=%b expected 1 after first pop", cmd_ready);
        end
        wait_idle(400);
    endtask

    task automatic test_nack();
        push_cmd(mk_exp(32'hA180_0064, 1'b0, 1'b0, 2, 1'b0), 1'b1);
        wait_idle(200);
    endtask

    task automatic test_late_ready();
        push_cmd(mk_exp(32'hC000_00FF, 1'b1, 1'b0, int'(RDY_TIMEOUT), 1'b0), 1'b1);
        push_cmd(mk_exp(32'h6000_0002, 1'b0, 1'b1, 0, 1'b1), 1'b1);
        wait_idle(400);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit saw_req = 1'b0;
        resp_en = 1'b0;
        push_cmd(mk_exp(32'h2A40_BEEF, 1'b1, 1'b0, 1, 1'b0), 1'b0);
        push_cmd(mk_exp(32'hE000_0055, 1'b1, 1'b0, 1, 1'b0), 1'b0);
        while (req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL mid_req: req=%b expected 1 within budget", req);
        end
        stat = 1'b1;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        tests++;
        if (ctrl !== 16'h2A40) begin
            fails++;
            $display("FAIL mid_hi: got %h expected 2a40", ctrl);
        end
        @(negedge clk);
        tests++;
        if (ctrl !== 16'hBEEF) begin
            fails++;
            $display("FAIL mid_lo: got %h expected beef", ctrl);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (req !== 1'b0 || ctrl !== 16'h0 || resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: got req=%b ctrl=%h rv=%b busy=%b rdy=%b expected 0 0000 0 0 1",
                     req, ctrl, resp_valid, busy, cmd_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req === 1'b1 || busy === 1'b1) saw_req = 1'b1;
        end
        tests++;
        if (saw_req) begin
            fails++;
            $display("FAIL dropped_queue: got activity=1 expected 0 after reset");
        end
        resp_en = 1'b1;
        push_cmd(mk_exp(32'hA180_0064, 1'b1, 1'b0, 1, 1'b0), 1'b1);
        wait_idle(200);
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_back_to_back();
        test_nack();
        test_late_ready();
        test_reset_mid();
        tests++;
        if (resp_q.size() != 0 || inst_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d responses %0d requests pending expected 0", resp_q.size(), inst_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
